// File: rtl/btn_input_conditioner.sv
// Multi-channel button front end: 2-flop synchroniser, debounce filter, edge pulses,
// long-press detection and auto-repeat, one independent slice per button.
module btn_input_conditioner #(
    parameter int NUM_BTN        = 3,
    parameter int CNT_WIDTH      = 20,
    parameter int DEBOUNCE_LIMIT = 1_000_000,
    parameter int HOLD_WIDTH     = 27,
    parameter int HOLD_LIMIT     = 100_000_000,
    parameter int REPEAT_LIMIT   = 20_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] clean_btn,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_press,
    output logic [NUM_BTN-1:0] repeat_pulse
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    localparam logic [CNT_WIDTH-1:0]  DCNT_LAST   = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST   = HOLD_WIDTH'(HOLD_LIMIT - 1);
    localparam logic [HOLD_WIDTH-1:0] REPEAT_LAST = HOLD_WIDTH'(REPEAT_LIMIT - 1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        logic                  s1;
        logic                  s2;
        logic [CNT_WIDTH-1:0]  dcnt;
        logic                  clean_q;
        logic                  press_q;
        logic                  release_q;
        logic [1:0]            state;
        logic [HOLD_WIDTH-1:0] hcnt;
        logic                  long_q;
        logic                  repeat_q;
        logic                  accept;

        // Sync disagrees with the clean level for the final required cycle.
        assign accept = (s2 != clean_q) && (dcnt == DCNT_LAST);

        // NOTE: s1 may go metastable; only s2 is ever looked at by the filter.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= btn[i];
                s2 <= s1;
            end
        end

        // NOTE: non-blocking assignments everywhere here, so every read sees the pre-edge value.
        always_ff @(posedge clk) begin
            if (reset) begin
                dcnt      <= '0;
                clean_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (s2 == clean_q) begin
                    dcnt <= '0;
                end else if (accept) begin
                    clean_q   <= s2;
                    dcnt      <= '0;
                    press_q   <= s2;
                    release_q <= ~s2;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

        // Release acceptance takes priority over any hold/repeat event on the same edge.
        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= ST_IDLE;
                hcnt     <= '0;
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
            end else begin
                repeat_q <= 1'b0;
                if (accept) begin
                    state  <= s2 ? ST_HOLD : ST_IDLE;
                    hcnt   <= '0;
                    long_q <= 1'b0;
                end else begin
                    case (state)
                        ST_HOLD: begin
                            if (hcnt == HOLD_LAST) begin
                                state    <= ST_LONG;
                                long_q   <= 1'b1;
                                hcnt     <= '0;
                                repeat_q <= repeat_en[i];
                            end else begin
                                hcnt <= hcnt + 1'b1;
                            end
                        end
                        ST_LONG: begin
                            if (hcnt == REPEAT_LAST) begin
                                hcnt     <= '0;
                                repeat_q <= repeat_en[i];
                            end else begin
                                hcnt <= hcnt + 1'b1;
                            end
                        end
                        default: begin
                            state  <= ST_IDLE;
                            hcnt   <= '0;
                            long_q <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign clean_btn[i]     = clean_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_press[i]    = long_q;
        assign repeat_pulse[i]  = repeat_q;
    end

endmodule

// File: doc/btn_input_conditioner.md
# btn_input_conditioner

Parametrised multi-channel button front end. Each of `NUM_BTN` raw, asynchronous button inputs passes through a 2-flop synchroniser and a debounce filter with a programmable limit. Each channel produces a clean level, one-cycle press and release pulses, a long-press level, and optional auto-repeat pulses. It sits between board pins and the control FSMs (stopwatch/clock mode logic), so downstream logic never needs its own edge detector.

## Interface
Clock `clk`, reset `reset`: one clock; reset is synchronous and active-high.

Parameters:
- `NUM_BTN`, 3: number of independent channels; ≥1.
- `CNT_WIDTH`, 20: debounce counter width; must hold `DEBOUNCE_LIMIT-1`.
- `DEBOUNCE_LIMIT`, 1_000_000: consecutive disagreeing cycles needed to accept a new level (10 ms at 100 MHz); ≥1.
- `HOLD_WIDTH`, 27: hold/repeat counter width; must hold max(`HOLD_LIMIT`,`REPEAT_LIMIT`)-1.
- `HOLD_LIMIT`, 100_000_000: cycles of clean-high before long press (1 s); ≥1.
- `REPEAT_LIMIT`, 20_000_000: auto-repeat period in cycles once long press is active (200 ms); ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn`  in  NUM_BTN  raw button levels; active-high; asynchronous.
- `repeat_en`  in  NUM_BTN  per-channel auto-repeat enable; synchronous to `clk`.
- `clean_btn`  out  NUM_BTN  debounced level.
- `press_pulse`  out  NUM_BTN  one-cycle pulse on accepted 0→1.
- `release_pulse`  out  NUM_BTN  one-cycle pulse on accepted 1→0.
- `long_press`  out  NUM_BTN  level: button held ≥ `HOLD_LIMIT` cycles after acceptance.
- `repeat_pulse`  out  NUM_BTN  one-cycle auto-repeat pulses.

## Operation
- Channels are fully independent. All outputs are registered.
- **Reset.** All sync flops, counters and outputs are cleared to 0.
- **Synchroniser.** `btn[i]` passes through `s1` and then `s2`. Only `s2` (`sync`) feeds the filter.
- **Debounce.**
  - If `sync == clean_btn`, then `dcnt` is set to 0.
  - Otherwise, if `dcnt == DEBOUNCE_LIMIT-1`, then `clean_btn` takes `sync` and `dcnt` is set to 0.
  - Otherwise, `dcnt` increments.
  - A bounce shorter than `DEBOUNCE_LIMIT` cycles restarts the count, and `clean_btn` does not change.
- **Edge pulses.**
  - `press_pulse` goes high on the same edge that `clean_btn` goes 0→1, and clears on the next edge.
  - `release_pulse` behaves the same way on the 1→0 transition.
  - The two pulses are never high together.
- **Hold FSM per channel.** States IDLE, HOLD and LONG.
  - IDLE: entered while `clean_btn`=0. `hcnt` is 0.
  - HOLD: entered on press acceptance. `hcnt` increments each cycle. When `hcnt == HOLD_LIMIT-1`, the FSM goes to LONG, `long_press` is set to 1, `hcnt` is set to 0, and `repeat_pulse` is set to `repeat_en[i]` for one cycle.
  - LONG: `hcnt` increments. When `hcnt == REPEAT_LIMIT-1`, `hcnt` is set to 0 and `repeat_pulse` is set to `repeat_en[i]` for one cycle. The counter runs whether or not repeat is enabled.
  - Release acceptance from HOLD or LONG goes to IDLE. `long_press` and `hcnt` clear on the same edge that `clean_btn` falls.
- **`repeat_en` timing.** `repeat_en` is sampled at each pulse opportunity. Toggling it mid-hold does not disturb the period phase.
- **Button held through reset.** After reset deasserts, the button is re-acquired as a fresh press: full latency, then `press_pulse`.
- **Reset during a hold.** The channel aborts to IDLE with all outputs 0. No release pulse is emitted.

## Timing
- Let edge 0 be the first edge after reset at which `s1` samples a new stable `btn` level.
  - `sync` changes after edge 1.
  - `clean_btn` and the corresponding edge pulse change at edge `1+DEBOUNCE_LIMIT`.
  - The pulse is high for exactly one cycle.
- `long_press` rises `HOLD_LIMIT` edges after `press_pulse`, together with the first `repeat_pulse` if enabled.
- Subsequent `repeat_pulse`s follow every `REPEAT_LIMIT` cycles.
- Release latency is identical to press latency. Outputs clear on that edge.
- Throughput: a new accepted transition at most once every `DEBOUNCE_LIMIT` cycles per channel.

## Test plan
Bench parameters: `NUM_BTN`=3, `DEBOUNCE_LIMIT`=4, `HOLD_LIMIT`=10, `REPEAT_LIMIT`=3.
- **Clean press.** `btn[0]` 0→1 sampled at edge 0 and held → `clean_btn[0]`=1 from edge 5. `press_pulse[0]` high only in the cycle after edge 5. Channels 1 and 2 stay 0.
- **Bounce rejection.** `btn[1]` toggles 1,0 every 2 cycles for 40 cycles, then settles at 0 → `clean_btn[1]` and all pulses on channel 1 remain 0.
- **Long press and repeat.** `repeat_en[2]`=1; hold `btn[2]` → `long_press[2]` rises at press edge + 10, with a `repeat_pulse` there and at +13, +16 and +19. Release → `long_press` and `clean_btn` fall at the same edge, with a single `release_pulse`.
- **Repeat disabled.** Same stimulus with `repeat_en[2]`=0 → `long_press` asserts and `repeat_pulse` stays 0. Setting `repeat_en` to 1 at press edge + 14 gives the first pulse at +16.
- **Reset mid-hold.** 1-cycle `reset` during LONG while `btn` stays high → all outputs 0 at the next edge, no `release_pulse`. `press_pulse` occurs again 5 edges after `s1` resamples `btn`.
- **Simultaneous channels.** All three `btn` bits rise on the same edge → identical `press_pulse` timing on all channels. Releasing channel 0 only does not affect channels 1 and 2.
